sigma_delta_adc_capture_ctrl: RTL and testbench
===============================================

// Module: sigma_delta_adc_capture_ctrl
// PURPOSE
//  Sequences one capture run of the sigma-delta ADC datapath (modulator -> CIC -> DC block).
//  On start: resets the decimator, discards the CIC/DC-block settling samples, then
//  captures CAPTURE_LEN decimated samples into an internal FIFO, drained over a ready/valid stream.
//  Sits between the ADC harness output (adc_output/adc_valid) and the downstream sample sink.
// PARAMETERS
//  ADC_BITLEN      22    width of adc_data and m_data
//  SETTLE_SAMPLES  4     valid samples discarded after decimator reset (>= CIC_STAGES+2)
//  CAPTURE_LEN     1024  samples captured per run (>= 1)
//  FIFO_DEPTH      16    output FIFO entries (power of two, >= 2)
//  ADC_RST_CYCLES  2     cycles adc_rst held high at run start (>= 1)
// PORTS
//  clk        in   1           system clock (BCLK domain of the modulator)
//  rst        in   1           synchronous, active-high reset
//  start      in   1           begin run; honoured only in IDLE
//  abort      in   1           cancel run from any state
//  adc_en     out  1           enable to ADC datapath
//  adc_rst    out  1           synchronous reset to CIC/DC-block
//  adc_valid  in   1           one-cycle strobe per decimated sample
//  adc_data   in   ADC_BITLEN  decimated sample, qualified by adc_valid
//  m_data     out  ADC_BITLEN  FIFO head
//  m_valid    out  1           FIFO non-empty
//  m_ready    in   1           sink accepts m_data when m_valid & m_ready
//  m_last     out  1           high with m_valid on final sample of the run
//  busy       out  1           state != IDLE
//  done       out  1           one-cycle pulse at run end (not on abort)
//  overflow   out  1           sticky: sample dropped on full FIFO; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; adc_en=0, adc_rst=0, m_valid=0, m_last=0, busy=0, done=0, overflow=0;
//   FIFO emptied, all counters 0. m_data don't-care while m_valid=0.
//  FSM (all outputs registered, transitions on clk):
//   IDLE    : start=1 -> FLUSH; clear overflow, FIFO, counters.
//   FLUSH   : adc_rst=1, adc_en=1 for ADC_RST_CYCLES cycles -> SETTLE.
//   SETTLE  : adc_en=1; count adc_valid strobes; on SETTLE_SAMPLES-th strobe -> CAPTURE.
//             Discarded strobes never reach the FIFO.
//   CAPTURE : adc_en=1; each adc_valid pushes adc_data; on CAPTURE_LEN-th strobe -> DRAIN.
//   DRAIN   : adc_en=0; wait for FIFO empty -> DONE.
//   DONE    : done=1 for one cycle -> IDLE.
//  adc_valid ignored in IDLE, FLUSH, DRAIN, DONE.
//  FIFO: first-word-fall-through; push in cycle N -> m_valid high in cycle N+1.
//   Pop on m_valid & m_ready. Push and pop same cycle when full: both succeed, count unchanged.
//   Push when full without pop: sample dropped, overflow<=1, still counts toward CAPTURE_LEN.
//  m_last tagged on the CAPTURE_LEN-th strobe's entry; if that sample is dropped, no m_last
//   is emitted for the run (overflow flags the fault).
//  Counters: settle counter $clog2(SETTLE_SAMPLES+1) bits, capture counter
//   $clog2(CAPTURE_LEN+1) bits; no wrap within a run.
//  abort (any non-IDLE state, priority over all transitions): next cycle state=IDLE,
//   adc_en=0, adc_rst=0, FIFO emptied (m_valid=0), done not pulsed, overflow retained.
//  start while busy ignored. start and abort same cycle in IDLE: abort wins, stay IDLE.
//  rst mid-run: same as reset values above, overflow cleared.
// TESTING
//  1 SETTLE_SAMPLES=4, CAPTURE_LEN=8, m_ready=1, strobe every 256 clks -> first 4 dropped,
//    next 8 emitted in order, m_last on 8th, done pulses once, overflow=0.
//  2 FIFO_DEPTH=4, CAPTURE_LEN=8, m_ready=0 until 8 strobes seen -> 4 held, overflow=1,
//    no m_last; after m_ready=1, 4 samples drain, done pulses.
//  3 abort on 3rd capture strobe -> next cycle busy=0, adc_en=0, m_valid=0, no done.
//  4 FIFO full and m_ready=1 on a strobe cycle -> push accepted, overflow stays 0.
//  5 start held high for 2 runs -> second run starts only after done; FLUSH holds
//    adc_rst high exactly ADC_RST_CYCLES=2 cycles each run.
//  6 rst asserted in CAPTURE -> next cycle all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/sigma_delta_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_adc_capture_ctrl
// Purpose  : Runs one ADC capture: decimator reset, settle discard, then
//            CAPTURE_LEN samples into a first-word-fall-through FIFO drained
//            over a ready/valid stream.
// Revision : 1.0
// ============================================================================
module sigma_delta_adc_capture_ctrl #(
  parameter int ADC_BITLEN     = 22,
  parameter int SETTLE_SAMPLES = 4,
  parameter int CAPTURE_LEN    = 1024,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADC_RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  adc_en,
  output logic                  adc_rst,
  input  logic                  adc_valid,
  input  logic [ADC_BITLEN-1:0] adc_data,
  output logic [ADC_BITLEN-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int FW = $clog2(ADC_RST_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam int CW = $clog2(CAPTURE_LEN + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [FW-1:0] FLUSH_LAST  = FW'(ADC_RST_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
  localparam logic [CW-1:0] CAP_LAST    = CW'(CAPTURE_LEN - 1);
  localparam logic [NW-1:0] FIFO_FULL   = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [FW-1:0] flush_cnt;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] cap_cnt;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] fifo_cnt;
  // Each entry carries its end-of-run tag in the MSB.
  logic [ADC_BITLEN:0] mem [FIFO_DEPTH];

  logic run_start, kill, fifo_empty, fifo_full;
  logic push_req, push_ok, pop, cap_last;

  assign run_start  = (state == S_IDLE) && start && !abort;
  assign kill       = abort && (state != S_IDLE);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign pop        = !fifo_empty && m_ready;
  assign push_req   = (state == S_CAPTURE) && adc_valid && !abort;
  // A full FIFO still takes the sample when the head leaves the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign cap_last   = (cap_cnt == CAP_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && !abort) state_nxt = S_FLUSH;
      S_FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = S_SETTLE;
      S_SETTLE:  if (adc_valid && (settle_cnt == SETTLE_LAST)) state_nxt = S_CAPTURE;
      S_CAPTURE: if (adc_valid && cap_last) state_nxt = S_DRAIN;
      S_DRAIN:   if (fifo_empty) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // Control outputs are decoded from the next state so they are true flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      adc_en  <= 1'b0;
      adc_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      adc_en  <= (state_nxt == S_FLUSH) || (state_nxt == S_SETTLE) || (state_nxt == S_CAPTURE);
      adc_rst <= (state_nxt == S_FLUSH);
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      flush_cnt  <= '0;
      settle_cnt <= '0;
      cap_cnt    <= '0;
    end else begin
      if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if ((state == S_SETTLE) && adc_valid) settle_cnt <= settle_cnt + 1'b1;
      if ((state == S_CAPTURE) && adc_valid) cap_cnt <= cap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill || run_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {cap_last, adc_data};
  end

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign m_valid = !fifo_empty;
  assign m_data  = mem[rd_ptr][ADC_BITLEN-1:0];
  assign m_last  = m_valid && mem[rd_ptr][ADC_BITLEN];

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_delta_adc_capture_ctrl
// Purpose  : Directed vector table plus corner sequences for the capture ctrl.
// Revision : 1.0
// ============================================================================
module tb_sigma_delta_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, adc_valid, m_ready;
  logic [21:0] adc_data;
  logic        adc_en, adc_rst, m_valid, m_last, busy, done, overflow;
  logic [21:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  logic [22:0] beat_q[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  sigma_delta_adc_capture_ctrl #(
    .ADC_BITLEN(22), .SETTLE_SAMPLES(4), .CAPTURE_LEN(8),
    .FIFO_DEPTH(4), .ADC_RST_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .adc_en(adc_en), .adc_rst(adc_rst), .adc_valid(adc_valid),
    .adc_data(adc_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  // Inputs only change just after posedge, so a beat seen here transfers next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  typedef struct packed {
    logic        s;
    logic        a;
    logic        v;
    logic [21:0] d;
    logic        r;
    logic [6:0]  fl;   // en, arst, mvalid, mlast, busy, done, overflow
    logic [21:0] md;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic s, input logic a, input logic v,
                              input logic [21:0] d, input logic r,
                              input logic [6:0] fl, input logic [21:0] md);
    vec_t t;
    t.s = s; t.a = a; t.v = v; t.d = d; t.r = r; t.fl = fl; t.md = md;
    return t;
  endfunction

  function automatic logic [28:0] outs();
    return {adc_en, adc_rst, m_valid, m_last, busy, done, overflow,
            (m_valid ? m_data : 22'h0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [21:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic run_to_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) strobe(22'h3FFFFF);
  endtask

  task automatic wait_idle(input int base_done);
    for (int c = 0; c < 40; c++) begin
      if ((done_cnt > base_done) && !busy) break;
      tick();
    end
  endtask

  initial begin
    int b0, d0, runs, rl, dn, bad_order;
    logic prev_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
    adc_data = '0; m_ready = 1'b1;
    tick(); tick();
    chk("reset_state", 64'(outs()), 64'd0);
    rst = 1'b0;
    tick();

    // Normal run, sink always ready; garbage strobes in FLUSH/DRAIN must be ignored.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 22'h0,   1'b1, 7'b1100100, 22'h0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 22'hBAD, 1'b1, 7'b1100100, 22'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 7'b1000100, 22'h0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 22'h101, 1'b1, 7'b1000100, 22'h0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 22'h102, 1'b1, 7'b1000100, 22'h0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 22'h103, 1'b1, 7'b1000100, 22'h0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 22'h104, 1'b1, 7'b1000100, 22'h0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 22'h011, 1'b1, 7'b1010100, 22'h011);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 22'h022, 1'b1, 7'b1010100, 22'h022);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 7'b1000100, 22'h0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 22'h033, 1'b1, 7'b1010100, 22'h033);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 22'h044, 1'b1, 7'b1010100, 22'h044);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 22'h055, 1'b1, 7'b1010100, 22'h055);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 22'h066, 1'b1, 7'b1010100, 22'h066);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 22'h077, 1'b1, 7'b1010100, 22'h077);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 22'h088, 1'b1, 7'b0011100, 22'h088);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 22'hBAD, 1'b1, 7'b0000100, 22'h0);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 7'b0000110, 22'h0);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 7'b0000000, 22'h0);

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].s; abort = tbl[i].a; adc_valid = tbl[i].v;
      adc_data = tbl[i].d; m_ready = tbl[i].r;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'({tbl[i].fl, tbl[i].md}));
    end
    start = 1'b0; adc_valid = 1'b0;

    // Sink stalled: only FIFO_DEPTH samples survive, the tagged last is dropped.
    m_ready = 1'b0;
    b0 = beat_q.size(); d0 = done_cnt;
    run_to_capture();
    for (int i = 0; i < 8; i++) strobe(22'(32'h1000 + i));
    chk("t2_stalled", 64'({overflow, adc_en, m_valid, m_last, m_data}),
        64'({1'b1, 1'b0, 1'b1, 1'b0, 22'h1000}));
    m_ready = 1'b1;
    wait_idle(d0);
    chk("t2_idle_done", 64'({busy, overflow, 32'(done_cnt - d0)}), 64'({1'b0, 1'b1, 32'd1}));
    chk("t2_beats", 64'(beat_q.size() - b0), 64'd4);
    for (int i = 0; i < 4; i++)
      if (beat_q.size() > b0 + i)
        chk($sformatf("t2_beat%0d", i), 64'(beat_q[b0 + i]), 64'({1'b0, 22'(32'h1000 + i)}));

    // Abort on the 3rd capture strobe; accepted start clears overflow first.
    m_ready = 1'b0;
    d0 = done_cnt;
    run_to_capture();
    chk("t3_ovf_cleared", 64'(overflow), 64'd0);
    strobe(22'h51); strobe(22'h52);
    abort = 1'b1; adc_valid = 1'b1; adc_data = 22'h53;
    tick();
    abort = 1'b0; adc_valid = 1'b0;
    chk("t3_abort", 64'({busy, adc_en, adc_rst, m_valid}), 64'd0);
    tick(); tick(); tick();
    chk("t3_no_done", 64'({busy, 32'(done_cnt - d0)}), 64'd0);

    // Abort must keep a sticky overflow.
    run_to_capture();
    for (int i = 0; i < 5; i++) strobe(22'(32'h60 + i));
    chk("ovf_set", 64'(overflow), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_keeps_ovf", 64'({busy, m_valid, overflow}), 64'({1'b0, 1'b0, 1'b1}));

    // start together with abort in IDLE stays IDLE.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_idle", 64'({busy, adc_en, adc_rst}), 64'd0);

    // Full FIFO with a ready sink on a strobe: push accepted, no overflow.
    m_ready = 1'b0;
    b0 = beat_q.size(); d0 = done_cnt;
    run_to_capture();
    for (int i = 0; i < 4; i++) strobe(22'(32'h2000 + i));
    chk("t4_full", 64'({m_valid, overflow}), 64'({1'b1, 1'b0}));
    m_ready = 1'b1;
    strobe(22'h2004);
    chk("t4_no_ovf", 64'(overflow), 64'd0);
    for (int i = 5; i < 8; i++) strobe(22'(32'h2000 + i));
    wait_idle(d0);
    chk("t4_done", 64'({busy, overflow, 32'(done_cnt - d0)}), 64'({1'b0, 1'b0, 32'd1}));
    chk("t4_beats", 64'(beat_q.size() - b0), 64'd8);
    for (int i = 0; i < 8; i++)
      if (beat_q.size() > b0 + i)
        chk($sformatf("t4_beat%0d", i), 64'(beat_q[b0 + i]),
            64'({(i == 7) ? 1'b1 : 1'b0, 22'(32'h2000 + i)}));

    // start held across two runs: the second FLUSH follows done plus one idle cycle.
    start = 1'b1; m_ready = 1'b1; adc_valid = 1'b1;
    runs = 0; rl = 0; dn = 0; bad_order = 0; prev_done = 1'b0;
    for (int c = 0; c < 120 && dn < 2; c++) begin
      adc_data = 22'(c);
      tick();
      if (prev_done) chk("t5_idle_gap", 64'(busy), 64'd0);
      if (adc_rst) begin
        if (rl == 0) begin
          if (runs != dn) bad_order = 1;
          runs++;
        end
        rl++;
      end else if (rl != 0) begin
        chk("t5_flush_len", 64'(rl), 64'd2);
        rl = 0;
      end
      prev_done = done;
      if (done) dn++;
    end
    start = 1'b0; adc_valid = 1'b0;
    chk("t5_two_runs", 64'({32'(dn), 32'(bad_order)}), 64'({32'd2, 32'd0}));
    tick();
    chk("t5_idle_after", 64'({busy, adc_rst}), 64'd0);

    // Reset in CAPTURE with a non-empty FIFO and overflow set.
    m_ready = 1'b0;
    run_to_capture();
    for (int i = 0; i < 5; i++) strobe(22'(32'h70 + i));
    rst = 1'b1; tick();
    chk("t6_rst", 64'(outs()), 64'd0);
    rst = 1'b0; tick();
    chk("t6_after_rst", 64'(outs()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
